// File: rtl/soc_evt_id_sender.sv
// SoC-event ID sender: counts per-source event pulses and sends one event ID per
// accepted transfer, with round-robin selection among pending sources.
module soc_evt_id_sender #(
  parameter int NB_EVT    = 8,
  parameter int ID_WIDTH  = 8,
  parameter int ID_BASE   = 0,
  parameter int CNT_WIDTH = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NB_EVT-1:0]   evt_i,
  output logic                evt_valid_o,
  input  logic                evt_fulln_i,
  output logic [ID_WIDTH-1:0] evt_data_o,
  output logic [NB_EVT-1:0]   ovf_o,
  input  logic                ovf_clr_i,
  output logic                busy_o
);

  localparam int PW = (NB_EVT > 1) ? $clog2(NB_EVT) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  if (NB_EVT < 2) begin : g_chk_nb
    $error("soc_evt_id_sender: NB_EVT must be >= 2");
  end
  if ((longint'(ID_BASE) + longint'(NB_EVT)) > (longint'(1) << ID_WIDTH)) begin : g_chk_id
    $error("soc_evt_id_sender: ID_BASE+NB_EVT does not fit in ID_WIDTH");
  end

  logic [CNT_WIDTH-1:0] cnt_q [NB_EVT];
  logic [CNT_WIDTH-1:0] cnt_d [NB_EVT];
  logic [PW-1:0]        ptr_q, ptr_d;
  logic                 valid_q, valid_d;
  logic [ID_WIDTH-1:0]  data_q, data_d;
  logic [NB_EVT-1:0]    ovf_q, ovf_d;
  logic [NB_EVT-1:0]    pend;
  logic [NB_EVT-1:0]    grant;
  logic                 load_ok;
  logic                 found;
  logic [PW-1:0]        win;
  logic [PW-1:0]        idx;

  always_comb begin
    for (int i = 0; i < NB_EVT; i++) begin
      pend[i] = |cnt_q[i];
    end
  end

  // First pending source at or above the pointer, wrapping around.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int off = 0; off < NB_EVT; off++) begin
      idx = PW'((int'(ptr_q) + off) % NB_EVT);
      if (!found && pend[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    load_ok = ~valid_q | evt_fulln_i;
    grant   = '0;
    valid_d = valid_q;
    data_d  = data_q;
    ptr_d   = ptr_q;
    if (load_ok) begin
      if (found) begin
        grant[win] = 1'b1;
        valid_d    = 1'b1;
        data_d     = ID_WIDTH'(ID_BASE) + ID_WIDTH'(win);
        ptr_d      = (win == PW'(NB_EVT - 1)) ? '0 : win + 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  // A pulse that arrives while the counter is full is lost and flagged; set beats clear.
  always_comb begin
    ovf_d = ovf_clr_i ? '0 : ovf_q;
    for (int i = 0; i < NB_EVT; i++) begin
      cnt_d[i] = cnt_q[i];
      if (evt_i[i] && !grant[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          ovf_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end else if (!evt_i[i] && grant[i]) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NB_EVT; i++) begin
        cnt_q[i] <= '0;
      end
      ptr_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      ovf_q   <= '0;
    end else begin
      for (int i = 0; i < NB_EVT; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  assign evt_valid_o = valid_q;
  assign evt_data_o  = data_q;
  assign ovf_o       = ovf_q;
  assign busy_o      = (|pend) | valid_q;

endmodule

// File: tb/tb_soc_evt_id_sender.sv
// Scoreboard bench for soc_evt_id_sender: a behavioural model predicts transfers and
// per-cycle status; a negedge monitor compares the DUT against those predictions.
module tb_soc_evt_id_sender;

  localparam int NB   = 8;
  localparam int IDW  = 8;
  localparam int BASE = 'h20;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic            clk;
  logic            rst_n;
  logic [NB-1:0]   evt_i;
  logic            evt_valid_o;
  logic            evt_fulln_i;
  logic [IDW-1:0]  evt_data_o;
  logic [NB-1:0]   ovf_o;
  logic            ovf_clr_i;
  logic            busy_o;

  soc_evt_id_sender #(
    .NB_EVT(NB), .ID_WIDTH(IDW), .ID_BASE(BASE), .CNT_WIDTH(CW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .evt_i(evt_i), .evt_valid_o(evt_valid_o),
    .evt_fulln_i(evt_fulln_i), .evt_data_o(evt_data_o), .ovf_o(ovf_o),
    .ovf_clr_i(ovf_clr_i), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int exp_q[$];
  int xfer_id1 = 0;
  bit chk_en = 0;

  // model state
  int      m_cnt[NB];
  int      m_ptr;
  bit      m_valid;
  int      m_data;
  bit [NB-1:0] m_ovf;

  // expected DUT-visible status for the current cycle
  bit          s_valid;
  int          s_data;
  bit [NB-1:0] s_ovf;
  bit          s_busy;

  task automatic snapshot();
    s_valid = m_valid;
    s_data  = m_data;
    s_ovf   = m_ovf;
    s_busy  = m_valid;
    for (int i = 0; i < NB; i++) if (m_cnt[i] > 0) s_busy = 1'b1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NB; i++) m_cnt[i] = 0;
    m_ptr = 0; m_valid = 0; m_data = 0; m_ovf = '0;
  endtask

  task automatic model_step(input logic [NB-1:0] e, input bit f, input bit c);
    int g;
    bit lok;
    lok = !m_valid || f;
    if (m_valid && f) exp_q.push_back(m_data);
    g = -1;
    if (lok) begin
      for (int off = 0; off < NB; off++) begin
        int k;
        k = (m_ptr + off) % NB;
        if (g < 0 && m_cnt[k] > 0) g = k;
      end
      if (g >= 0) begin
        m_valid = 1; m_data = BASE + g; m_ptr = (g + 1) % NB;
      end else begin
        m_valid = 0;
      end
    end
    if (c) m_ovf = '0;
    for (int i = 0; i < NB; i++) begin
      if (e[i] && i != g) begin
        if (m_cnt[i] == CMAX) m_ovf[i] = 1'b1;
        else m_cnt[i]++;
      end else if (!e[i] && i == g) begin
        m_cnt[i]--;
      end
    end
  endtask

  task automatic cyc(input logic [NB-1:0] e, input bit f, input bit c);
    @(negedge clk);
    rst_n = 1'b1;
    evt_i = e; evt_fulln_i = f; ovf_clr_i = c;
    snapshot();
    model_step(e, f, c);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    evt_i = '0; ovf_clr_i = 1'b0;
    model_reset();
    exp_q.delete();
    snapshot();
    chk_en = 1'b1;
  endtask

  task automatic idle(input int n, input bit f);
    for (int i = 0; i < n; i++) cyc('0, f, 1'b0);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    #1;
    if (chk_en) begin
      total++;
      if (evt_valid_o !== s_valid) begin
        bad++; $display("FAIL valid: got %0b want %0b at %0t", evt_valid_o, s_valid, $time);
      end
      total++;
      if (busy_o !== s_busy) begin
        bad++; $display("FAIL busy: got %0b want %0b at %0t", busy_o, s_busy, $time);
      end
      total++;
      if (ovf_o !== s_ovf) begin
        bad++; $display("FAIL ovf: got %h want %h at %0t", ovf_o, s_ovf, $time);
      end
      if (s_valid) begin
        total++;
        if (evt_data_o !== IDW'(s_data)) begin
          bad++; $display("FAIL data: got %h want %h at %0t", evt_data_o, IDW'(s_data), $time);
        end
      end
      if (evt_valid_o === 1'b1 && evt_fulln_i === 1'b1) begin
        total++;
        if (evt_data_o == IDW'(BASE + 1)) xfer_id1++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL xfer: got %h want none at %0t", evt_data_o, $time);
        end else begin
          int ex;
          ex = exp_q.pop_front();
          if (evt_data_o !== IDW'(ex)) begin
            bad++; $display("FAIL xfer: got %h want %h at %0t", evt_data_o, IDW'(ex), $time);
          end
        end
      end
    end
  end

  int n0;

  initial begin
    rst_n = 1'b1; evt_i = '0; evt_fulln_i = 1'b1; ovf_clr_i = 1'b0;
    model_reset();
    do_reset();
    do_reset();

    // single pulse on source 3
    cyc(8'h08, 1'b1, 1'b0);
    idle(5, 1'b1);

    // back-pressure hold on source 5
    cyc(8'h20, 1'b0, 1'b0);
    idle(6, 1'b0);
    idle(3, 1'b1);

    // sources 0 and 2 pulse twice under back-pressure
    cyc(8'h05, 1'b0, 1'b0);
    cyc(8'h05, 1'b0, 1'b0);
    idle(3, 1'b0);
    idle(6, 1'b1);

    // saturation on source 1
    for (int i = 0; i < 5; i++) cyc(8'h02, 1'b0, 1'b0);
    idle(2, 1'b0);
    #2;
    n0 = xfer_id1;
    idle(8, 1'b1);
    #2;
    total++;
    if (xfer_id1 - n0 != 4) begin
      bad++; $display("FAIL sat_xfers: got %0d want 4", xfer_id1 - n0);
    end
    cyc('0, 1'b1, 1'b1);
    idle(2, 1'b1);

    // pulse on source 4 in the cycle it is granted
    cyc(8'h10, 1'b1, 1'b0);
    cyc(8'h10, 1'b1, 1'b0);
    idle(4, 1'b1);

    // reset while valid is high with pending counts
    cyc(8'hC0, 1'b0, 1'b0);
    cyc(8'hC0, 1'b0, 1'b0);
    idle(1, 1'b0);
    do_reset();
    idle(5, 1'b1);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [NB-1:0] e;
      bit f, c;
      e = '0;
      for (int i = 0; i < NB; i++) e[i] = ($urandom_range(0, 5) == 0);
      f = ($urandom_range(0, 9) < 6);
      c = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 599) == 0) do_reset();
      else cyc(e, f, c);
    end
    idle(40, 1'b1);
    #2;

    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL leftover: got %0d want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
